imm_extend_stage: RTL



---
 rtl/imm_extend_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/imm_extend_stage.sv
// Registered immediate-generation stage for the decode pipeline.
// Extracts in_instr[IMM_W-1:0], extends it to OUT_W using one of four modes,
// and presents it through a valid/ready handshake. A one-entry skid buffer
// catches the single in-flight immediate that arrives while the output stalls.
module imm_extend_stage #(
    parameter int INSTR_W = 32,
    parameter int IMM_W   = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_imm
);

    typedef enum logic [1:0] {
        MODE_SEXT     = 2'd0,
        MODE_ZEXT     = 2'd1,
        MODE_SEXT_SHL = 2'd2,
        MODE_UPPER    = 2'd3
    } mode_e;

    mode_e              mode;
    logic [IMM_W-1:0]   imm;
    logic [OUT_W-1:0]   imm_sext;
    logic [OUT_W-1:0]   imm_zext;
    logic [OUT_W-1:0]   imm_ext;

    // Architectural state
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_imm_q;
    logic               skid_valid_q;
    logic [OUT_W-1:0]   skid_data_q;
    logic               in_ready_q;

    // Next-state values
    logic               out_valid_d;
    logic [OUT_W-1:0]   out_imm_d;
    logic               skid_valid_d;
    logic [OUT_W-1:0]   skid_data_d;
    logic               in_ready_d;

    logic               accept;
    logic               drain;

    assign mode = mode_e'(in_mode);
    assign imm  = in_instr[IMM_W-1:0];

    // Instruction bits above the immediate field are intentionally ignored.
    generate
        if (INSTR_W > IMM_W) begin : g_unused_hi
            logic unused_instr_hi;
            assign unused_instr_hi = ^in_instr[INSTR_W-1:IMM_W];
        end
    endgenerate

    // Sign extension built bit by bit so OUT_W == IMM_W needs no zero-width replication.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default first, so no path can infer a latch.
        imm_sext = '0;
        for (int i = 0; i < OUT_W; i++) begin
            imm_sext[i] = (i < IMM_W) ? imm[i] : imm[IMM_W-1];
        end
    end

    assign imm_zext = OUT_W'(imm);

    // Mode select: sign, zero, sign-then-shift (branch offset), or upper placement.
    always_comb begin
        imm_ext = imm_sext;
        case (mode)
            MODE_SEXT:     imm_ext = imm_sext;
            MODE_ZEXT:     imm_ext = imm_zext;
            MODE_SEXT_SHL: imm_ext = imm_sext << SHAMT;
            MODE_UPPER:    imm_ext = imm_zext << (OUT_W - IMM_W);
            default:       imm_ext = imm_sext;
        endcase
    end

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    // Handshake next state: flush wins, then refill output from skid (FIFO), then from input.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                // in_ready is low whenever skid is full, so no accept competes here.
                out_valid_d  = 1'b1;
                out_imm_d    = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = imm_ext;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = imm_ext;
        end
        // Registered ready tracks the upcoming skid occupancy, so a full skid blocks the very next cycle.
        in_ready_d = !skid_valid_d;
    end

    // State registers; every held value, skid data included, clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign in_ready  = in_ready_q;

endmodule
